fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding + hazard unit for the 5-stage MIPS pipeline. Generates EX-stage and
//  ID-branch operand bypass selects for NUM_SRC read ports and hi/lo bypass selects. Also

---
 rtl/fwd_hazard_unit.sv | 126 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the 5-stage MIPS pipeline: operand/hi-lo bypass selects,
// load-use and divide interlocks, saturating stall counter. Divide interlock under FWD_DIV_INTERLOCK_EN.
module fwd_hazard_unit #(
  parameter int unsigned AW         = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC*AW-1:0]   src_addr_id,
  input  logic [NUM_SRC-1:0]      src_rd_id,
  input  logic                    is_branch_id,
  input  logic                    hilo_use_id,
  input  logic [NUM_SRC*AW-1:0]   src_addr_ex,
  input  logic [AW-1:0]           target_ex,
  input  logic                    we_ex,
  input  logic                    load_ex,
  input  logic                    div_start_ex,
  input  logic [AW-1:0]           src_addr_mem,
  input  logic [AW-1:0]           target_mem,
  input  logic                    we_mem,
  input  logic                    load_mem,
  input  logic                    we_hi_mem,
  input  logic                    we_lo_mem,
  input  logic [AW-1:0]           target_wb,
  input  logic                    we_wb,
  input  logic                    we_hi_wb,
  input  logic                    we_lo_wb,
  output logic [2*NUM_SRC-1:0]    fw_ex,
  output logic [2*NUM_SRC-1:0]    fw_br,
  output logic [1:0]              fw_hi,
  output logic [1:0]              fw_lo,
  output logic                    fw_ls,
  output logic                    stall_id,
  output logic                    bubble_ex,
  output logic                    div_busy,
  output logic                    div_done,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic load_use;
  logic div_hold;
  logic stall;

  // Register 0 is hardwired, so a zero target never produces a match.
  function automatic logic hit(input logic [AW-1:0] a, input logic [AW-1:0] t, input logic we);
    return we && (t != '0) && (a == t);
  endfunction

  always_comb begin
    fw_ex    = '0;
    fw_br    = '0;
    fw_hi    = 2'd0;
    fw_lo    = 2'd0;
    fw_ls    = 1'b0;
    load_use = 1'b0;
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (hit(src_addr_ex[i*AW +: AW], target_mem, we_mem))
          fw_ex[2*i +: 2] = 2'd1;
        else if (hit(src_addr_ex[i*AW +: AW], target_wb, we_wb))
          fw_ex[2*i +: 2] = 2'd2;

        // A load still in EX has no data yet; fall through to the MEM producer.
        if (hit(src_addr_id[i*AW +: AW], target_ex, we_ex) && !load_ex)
          fw_br[2*i +: 2] = 2'd1;
        else if (hit(src_addr_id[i*AW +: AW], target_mem, we_mem))
          fw_br[2*i +: 2] = load_mem ? 2'd3 : 2'd2;

        if (src_rd_id[i] && load_ex && hit(src_addr_id[i*AW +: AW], target_ex, we_ex))
          load_use = 1'b1;
      end

      if (we_hi_mem)     fw_hi = 2'd1;
      else if (we_hi_wb) fw_hi = 2'd2;

      if (we_lo_mem)     fw_lo = 2'd1;
      else if (we_lo_wb) fw_lo = 2'd2;

      fw_ls = hit(src_addr_mem, target_wb, we_wb);
    end
  end

`ifdef FWD_DIV_INTERLOCK_EN
  localparam int unsigned DW = $clog2(DIV_CYCLES + 1);

  logic [DW-1:0] div_cnt;
  logic          unused_ok;

  // Busy counter: loads on a start when idle, then counts down to zero; starts while busy are ignored.
  always_ff @(posedge clk) begin
    if (rst)
      div_cnt <= '0;
    else if (div_cnt != '0)
      div_cnt <= div_cnt - DW'(1);
    else if (div_start_ex)
      div_cnt <= DW'(DIV_CYCLES);
  end

  assign div_busy  = !rst && (div_cnt != '0);
  assign div_done  = !rst && (div_cnt == DW'(1));
  assign div_hold  = !rst && hilo_use_id && (div_busy || div_start_ex);
  assign unused_ok = is_branch_id;
`else
  logic unused_ok;

  assign div_busy  = 1'b0;
  assign div_done  = 1'b0;
  assign div_hold  = 1'b0;
  assign unused_ok = ^{is_branch_id, div_start_ex, hilo_use_id, 32'(DIV_CYCLES)};
`endif

  assign stall     = load_use | div_hold;
  assign stall_id  = stall;
  assign bubble_ex = stall;

  // Saturating count of stalled cycles since reset.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios then random traffic against a
// cycle-indexed reference model. Follows FWD_DIV_INTERLOCK_EN if defined for the build.
module tb_fwd_hazard_unit;
  localparam int DIVC = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] sid0, sid1, sex0, sex1;
  logic [1:0] src_rd_id;
  logic is_branch_id, hilo_use_id;
  logic [4:0] target_ex, src_addr_mem, target_mem, target_wb;
  logic we_ex, load_ex, div_start_ex, we_mem, load_mem, we_hi_mem, we_lo_mem;
  logic we_wb, we_hi_wb, we_lo_wb;

  logic [3:0] fw_ex, fw_br;
  logic [1:0] fw_hi, fw_lo;
  logic fw_ls, stall_id, bubble_ex, div_busy, div_done;
  logic [3:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycle index, start cycle of the running divide, stall total.
  int cyc = 0;
  int div_t = -1;
  int stalls = 0;

  logic [3:0] e_fw_ex, e_fw_br;
  logic [1:0] e_fw_hi, e_fw_lo;
  logic e_fw_ls, e_stall, e_busy, e_done;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.AW(5), .NUM_SRC(2), .DIV_CYCLES(DIVC), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .src_addr_id({sid1, sid0}), .src_rd_id(src_rd_id),
    .is_branch_id(is_branch_id), .hilo_use_id(hilo_use_id),
    .src_addr_ex({sex1, sex0}),
    .target_ex(target_ex), .we_ex(we_ex), .load_ex(load_ex), .div_start_ex(div_start_ex),
    .src_addr_mem(src_addr_mem), .target_mem(target_mem), .we_mem(we_mem), .load_mem(load_mem),
    .we_hi_mem(we_hi_mem), .we_lo_mem(we_lo_mem),
    .target_wb(target_wb), .we_wb(we_wb), .we_hi_wb(we_hi_wb), .we_lo_wb(we_lo_wb),
    .fw_ex(fw_ex), .fw_br(fw_br), .fw_hi(fw_hi), .fw_lo(fw_lo), .fw_ls(fw_ls),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .div_busy(div_busy), .div_done(div_done),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m(input logic [4:0] a, input logic [4:0] t, input logic we);
    return we && t != 5'd0 && a == t;
  endfunction

  function automatic bit m_busy();
`ifdef FWD_DIV_INTERLOCK_EN
    return div_t >= 0 && cyc > div_t && cyc <= div_t + DIVC;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_comb();
    logic [4:0] ai[2];
    logic [4:0] ae[2];
    bit lu;
    bit dh;
    ai[0] = sid0; ai[1] = sid1; ae[0] = sex0; ae[1] = sex1;
    e_fw_ex = '0; e_fw_br = '0; e_fw_hi = 2'd0; e_fw_lo = 2'd0; e_fw_ls = 1'b0;
    e_stall = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    lu = 1'b0; dh = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        logic [1:0] sel;
        sel = m(ae[i], target_mem, we_mem) ? 2'd1 : m(ae[i], target_wb, we_wb) ? 2'd2 : 2'd0;
        e_fw_ex[2*i +: 2] = sel;
        if (m(ai[i], target_ex, we_ex) && !load_ex) sel = 2'd1;
        else if (m(ai[i], target_mem, we_mem)) sel = load_mem ? 2'd3 : 2'd2;
        else sel = 2'd0;
        e_fw_br[2*i +: 2] = sel;
        if (src_rd_id[i] && load_ex && m(ai[i], target_ex, we_ex)) lu = 1'b1;
      end
      e_fw_hi = we_hi_mem ? 2'd1 : we_hi_wb ? 2'd2 : 2'd0;
      e_fw_lo = we_lo_mem ? 2'd1 : we_lo_wb ? 2'd2 : 2'd0;
      e_fw_ls = m(src_addr_mem, target_wb, we_wb);
      e_busy = m_busy();
`ifdef FWD_DIV_INTERLOCK_EN
      e_done = div_t >= 0 && cyc == div_t + DIVC;
      dh = hilo_use_id && (e_busy || div_start_ex);
`endif
      e_stall = lu || dh;
    end
  endtask

  // Settle inputs, then compare every output against the model.
  task automatic eval();
    #1;
    model_comb();
    chk("fw_ex", 32'(fw_ex), 32'(e_fw_ex));
    chk("fw_br", 32'(fw_br), 32'(e_fw_br));
    chk("fw_hi", 32'(fw_hi), 32'(e_fw_hi));
    chk("fw_lo", 32'(fw_lo), 32'(e_fw_lo));
    chk("fw_ls", 32'(fw_ls), 32'(e_fw_ls));
    chk("stall_id", 32'(stall_id), 32'(e_stall));
    chk("bubble_ex", 32'(bubble_ex), 32'(e_stall));
    chk("div_busy", 32'(div_busy), 32'(e_busy));
    chk("div_done", 32'(div_done), 32'(e_done));
    chk("stall_cnt", 32'(stall_cnt), 32'(stalls > CMAX ? CMAX : stalls));
  endtask

  task automatic adv();
    if (rst) begin
      div_t = -1;
      stalls = 0;
    end else begin
      if (e_stall) stalls++;
      if (div_start_ex && !m_busy()) div_t = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 1'b0; sid0 = '0; sid1 = '0; sex0 = '0; sex1 = '0; src_rd_id = '0;
    is_branch_id = 1'b0; hilo_use_id = 1'b0; target_ex = '0; we_ex = 1'b0; load_ex = 1'b0;
    div_start_ex = 1'b0; src_addr_mem = '0; target_mem = '0; we_mem = 1'b0; load_mem = 1'b0;
    we_hi_mem = 1'b0; we_lo_mem = 1'b0; target_wb = '0; we_wb = 1'b0;
    we_hi_wb = 1'b0; we_lo_wb = 1'b0;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Reset state
    eval();
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    adv();

    // 1: MEM priority over WB, target 0 never matches, WB-only forward
    clr(); sex0 = 5'd3; target_mem = 5'd3; we_mem = 1'b1; target_wb = 5'd3; we_wb = 1'b1;
    eval(); chk("t1_mem_prio", 32'(fw_ex[1:0]), 32'd1); adv();
    sex0 = 5'd0; target_mem = 5'd0; target_wb = 5'd0;
    eval(); chk("t1_zero", 32'(fw_ex[1:0]), 32'd0); adv();
    sex1 = 5'd7; target_mem = 5'd6; target_wb = 5'd7;
    eval(); chk("t1_wb", 32'(fw_ex[3:2]), 32'd2); adv();

    // 2: load-use on port 1 stalls once, retry forwards from MEM
    clr(); sid0 = 5'd9; sid1 = 5'd4; src_rd_id = 2'b01; target_ex = 5'd4; we_ex = 1'b1; load_ex = 1'b1;
    eval(); chk("t2_unread", 32'(stall_id), 32'd0); adv();
    src_rd_id = 2'b10;
    eval(); chk("t2_stall", 32'(stall_id), 32'd1); chk("t2_bubble", 32'(bubble_ex), 32'd1); adv();
    target_ex = 5'd0; we_ex = 1'b0; load_ex = 1'b0; sex0 = 5'd9; sex1 = 5'd4;
    target_mem = 5'd4; we_mem = 1'b1; load_mem = 1'b1;
    eval(); chk("t2_retry_ex", 32'(fw_ex[3:2]), 32'd1); chk("t2_retry_br", 32'(fw_br[3:2]), 32'd3);
    chk("t2_nostall", 32'(stall_id), 32'd0); adv();

    // 3: branch operand from EX ALU, then MEM ALU; hi/lo and store-data bypass
    clr(); is_branch_id = 1'b1; sid0 = 5'd5; src_rd_id = 2'b01; target_ex = 5'd5; we_ex = 1'b1;
    eval(); chk("t3_br_ex", 32'(fw_br[1:0]), 32'd1); chk("t3_nostall", 32'(stall_id), 32'd0); adv();
    target_ex = 5'd0; target_mem = 5'd5; we_mem = 1'b1;
    we_hi_mem = 1'b1; we_hi_wb = 1'b1; we_lo_wb = 1'b1;
    src_addr_mem = 5'd6; target_wb = 5'd6; we_wb = 1'b1;
    eval(); chk("t3_br_mem", 32'(fw_br[1:0]), 32'd2); chk("t3_hi", 32'(fw_hi), 32'd1);
    chk("t3_lo", 32'(fw_lo), 32'd2); chk("t3_ls", 32'(fw_ls), 32'd1); adv();

    // 4: divide started, mflo waits in ID
    clr(); div_start_ex = 1'b1;
    eval(); adv();
    div_start_ex = 1'b0; hilo_use_id = 1'b1;
    for (int k = 1; k <= DIVC + 1; k++) begin
      eval();
`ifdef FWD_DIV_INTERLOCK_EN
      chk("t4_stall", 32'(stall_id), (k <= DIVC) ? 32'd1 : 32'd0);
      chk("t4_done", 32'(div_done), (k == DIVC) ? 32'd1 : 32'd0);
`else
      chk("t4_stall", 32'(stall_id), 32'd0);
      chk("t4_busy", 32'(div_busy), 32'd0);
`endif
      adv();
    end
`ifdef FWD_DIV_INTERLOCK_EN
    chk("t4_cnt", 32'(stall_cnt), 32'd5);
`else
    chk("t4_cnt", 32'(stall_cnt), 32'd1);
`endif

    // 5: reset in the middle of a divide aborts it without a done pulse
    clr(); div_start_ex = 1'b1;
    eval(); adv();
    div_start_ex = 1'b0; hilo_use_id = 1'b1;
    eval(); adv();
    rst = 1'b1;
    eval(); chk("t5_rst_stall", 32'(stall_id), 32'd0); adv();
    rst = 1'b0;
    eval(); chk("t5_busy", 32'(div_busy), 32'd0); chk("t5_stall", 32'(stall_id), 32'd0);
    chk("t5_cnt", 32'(stall_cnt), 32'd0); adv();
    for (int k = 0; k < DIVC; k++) begin
      eval(); chk("t5_nodone", 32'(div_done), 32'd0); adv();
    end

    // 6: stall counter saturates
    clr(); sid0 = 5'd4; src_rd_id = 2'b01; target_ex = 5'd4; we_ex = 1'b1; load_ex = 1'b1;
    for (int k = 0; k < 20; k++) begin
      eval(); adv();
    end
    eval(); chk("t6_sat", 32'(stall_cnt), 32'd15); adv();
    eval(); chk("t6_hold", 32'(stall_cnt), 32'd15); adv();

    // Random traffic over a small register window to make matches frequent
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 60) == 0);
      sid0 = 5'($urandom_range(0, 3)); sid1 = 5'($urandom_range(0, 3));
      sex0 = 5'($urandom_range(0, 3)); sex1 = 5'($urandom_range(0, 3));
      src_rd_id = 2'($urandom_range(0, 3));
      is_branch_id = 1'($urandom_range(0, 1));
      hilo_use_id = ($urandom_range(0, 2) == 0);
      target_ex = 5'($urandom_range(0, 3)); we_ex = 1'($urandom_range(0, 1));
      load_ex = 1'($urandom_range(0, 1));
      div_start_ex = ($urandom_range(0, 9) == 0);
      src_addr_mem = 5'($urandom_range(0, 3));
      target_mem = 5'($urandom_range(0, 3)); we_mem = 1'($urandom_range(0, 1));
      load_mem = 1'($urandom_range(0, 1));
      we_hi_mem = 1'($urandom_range(0, 1)); we_lo_mem = 1'($urandom_range(0, 1));
      target_wb = 5'($urandom_range(0, 3)); we_wb = 1'($urandom_range(0, 1));
      we_hi_wb = 1'($urandom_range(0, 1)); we_lo_wb = 1'($urandom_range(0, 1));
      eval();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
